display_capture: RTL and testbench
==================================

# display_capture

Receiver for the result-display stream driven by the display unit. It samples `display_result` and `display_current_state`, rebuilds the three 2x2 result matrices (single PE, 3x3 systolic array, 2x2 systolic array), and reports when all three have arrived. It then flags whether the three matrices agree, and flags any malformed stream. It sits beside the top-level design, in the bench harness or on-chip as a self-check, and consumes only the two display outputs.

## Interface
- `HOLD`, default 1: cycles each result element is held on `display_result`; valid range 1–255.
- `clk`  in  1  rising-edge clock, same domain as the display unit.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous; discards all captured data and returns to IDLE.
- `display_result`  in  8  current result element.
- `display_current_state`  in  3  source code: 0 idle, 1 PE, 2 SA_3x3, 3 SA_2x2, 4–7 illegal.
- `res_pe`  out  32  PE result matrix, packed {c11,c12,c21,c22}.
- `res_3x3`  out  32  3x3-array result matrix, same packing.
- `res_2x2`  out  32  2x2-array result matrix, same packing.
- `have`  out  3  sticky per-source capture-complete flags, bit0 PE, bit1 3x3, bit2 2x2.
- `done`  out  1  all three matrices captured; sticky until `clear` or reset.
- `match`  out  1  `res_pe == res_3x3 == res_2x2`; meaningful only while `done`=1.
- `proto_err`  out  1  sticky; the stream violated the protocol.

## Operation
- Stream contract: a source code of 1–3 is held for exactly 4*HOLD cycles. During that window `display_result` carries c11, c12, c21, c22, each for HOLD cycles. Code 0 means no data.
- FSM states:
  - IDLE: wait for a nonzero code. A legal code 1–3 enters CAPTURE with element index 0 and hold counter 0.
  - CAPTURE: the hold counter counts 0..HOLD-1. On HOLD-1, `display_result` is written into a staging register at the current element index, and the index advances.
    - After element 3 is sampled, the staging word is committed to the matching `res_*` output and its `have` bit is set.
    - Next state: CHECK if all three `have` bits are now set, otherwise IDLE.
  - CHECK: one cycle. Registers `done`=1 and `match` from the three result words, then moves to DONE.
  - DONE: ignores the stream. Only `clear` or reset leave it.
- Re-capture of a source already marked in `have`: the new data overwrites the old result. This is legal and is not an error.
- Protocol errors set `proto_err`, discard the staging word, and return to IDLE. Committed results are kept. The errors are:
  - The code changes in CAPTURE before element 3 is sampled.
  - The code is 4–7 in any state other than DONE.
- After a source's last sample the code may stay at the same value for any number of cycles. This is not an error, and the same window is not re-captured until the code passes through 0 or another source.
- Widths: all data are 8-bit unsigned. There is no arithmetic beyond the 8-bit hold counter and the 2-bit element index.

## Timing
- Reset and `clear` values: every `res_*`=0, `have`=0, `done`=0, `match`=0, `proto_err`=0, FSM=IDLE.
- `clear` takes priority over every other event in the same cycle.
- Sampling point: the last cycle of each element's HOLD window.
- A `res_*` word and its `have` bit update on the edge after element 3's sampling cycle.
- `done` and `match` rise 2 cycles after the final sample of the third source (commit edge, then CHECK edge).
- Reset asserted mid-capture clears state asynchronously. The first capture after release starts only on a fresh code transition out of 0 or into a new source.

## Structure
- Shared package `display_pkg`:
  - source-code constants `SRC_IDLE`=0, `SRC_PE`=1, `SRC_SA3`=2, `SRC_SA2`=3;
  - FSM state enum;
  - packing helper for the {c11,c12,c21,c22} order.
- One sub-module, `elem_sampler`: the hold counter and element index. It outputs `sample_strobe` and `last_elem`, and is reused by the display unit's own bench.

## Test plan
- HOLD=1. Stream PE {1,2,3,4}, 3x3 {1,2,3,4}, 2x2 {1,2,3,4} back-to-back -> `res_*`=32'h01020304 and `have`=3'b111. `done`=1 and `match`=1 two cycles after the last sample.
- HOLD=4. Same as above, but 2x2 carries {1,2,3,5} -> `res_2x2`=32'h01020305, `done`=1, `match`=0.
- HOLD=1. Code changes from 1 to 2 after 2 elements -> `proto_err`=1, `have[0]`=0. The following full SA_3x3 window is still captured.
- HOLD=1. Code 3'd5 appears in IDLE -> `proto_err`=1 and nothing is captured.
- HOLD=1. Capture PE, then assert reset at element 2 of SA_3x3 -> all outputs read 0 immediately. Replaying the full stream afterwards gives `done`=1.
- HOLD=1. `done`=1, then assert `clear` in the same cycle a new code-1 window starts -> all outputs 0 and FSM=IDLE. That window is not captured.

Source files
------------

// File: rtl/display_capture_pkg.sv
// Shared types and constants for the display result stream and its capture logic.
package display_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned NSRC   = 3;

    localparam logic [SRC_W-1:0] SRC_IDLE = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_PE   = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_SA3  = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_SA2  = SRC_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_CHECK,
        ST_DONE
    } cap_state_e;

    // 2x2 result matrix, c11 in the most significant byte
    typedef struct packed {
        logic [DATA_W-1:0] c11;
        logic [DATA_W-1:0] c12;
        logic [DATA_W-1:0] c21;
        logic [DATA_W-1:0] c22;
    } res_mat_t;

    function automatic res_mat_t pack_res(input logic [DATA_W-1:0] c11,
                                          input logic [DATA_W-1:0] c12,
                                          input logic [DATA_W-1:0] c21,
                                          input logic [DATA_W-1:0] c22);
        res_mat_t m;
        m.c11 = c11;
        m.c12 = c12;
        m.c21 = c21;
        m.c22 = c22;
        return m;
    endfunction

    function automatic logic is_legal_src(input logic [SRC_W-1:0] code);
        return (code >= SRC_PE) && (code <= SRC_SA2);
    endfunction

endpackage

// File: rtl/display_capture_if.sv
// Display stream input and capture result bundle between the stream driver and display_capture.
interface display_capture_if;
    import display_pkg::*;

    logic              clear;
    logic [DATA_W-1:0] display_result;
    logic [SRC_W-1:0]  display_current_state;

    res_mat_t          res_pe;
    res_mat_t          res_3x3;
    res_mat_t          res_2x2;
    logic [NSRC-1:0]   have;
    logic              done;
    logic              match;
    logic              proto_err;

    modport master (
        output clear, display_result, display_current_state,
        input  res_pe, res_3x3, res_2x2, have, done, match, proto_err
    );

    modport slave (
        input  clear, display_result, display_current_state,
        output res_pe, res_3x3, res_2x2, have, done, match, proto_err
    );

endinterface

// File: rtl/display_capture_elem_sampler.sv
// Hold counter and element index for a 4-element stream window; strobes on each element's last hold cycle.
module elem_sampler
    import display_pkg::*;
#(
    parameter int unsigned HOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_start,
    input  logic             i_run,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_sample_strobe_c,
    output logic             o_last_elem_c
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(3);

    logic [HOLD_W-1:0] r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [HOLD_W-1:0] w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic              w_act;

    // A start cycle is itself hold cycle 0 of element 0, so it ignores the stored count
    always_comb begin
        w_act             = i_start | i_run;
        w_cnt             = i_start ? '0 : r_cnt;
        w_idx             = i_start ? '0 : r_idx;
        o_idx_c           = w_idx;
        o_sample_strobe_c = w_act && (w_cnt == HOLD_LAST);
        o_last_elem_c     = o_sample_strobe_c && (w_idx == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_clear || !w_act) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (o_sample_strobe_c) begin
            r_cnt <= '0;
            r_idx <= w_idx + IDX_W'(1);
        end else begin
            r_cnt <= w_cnt + HOLD_W'(1);
            r_idx <= w_idx;
        end
    end

endmodule

// File: rtl/display_capture.sv
// Rebuilds the PE / 3x3 / 2x2 result matrices from the display stream, checks agreement and protocol.
module display_capture
    import display_pkg::*;
#(
    parameter int unsigned HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    display_capture_if.slave bus
);

    cap_state_e             r_state,     w_state;
    logic [SRC_W-1:0]       r_cur_src,   w_cur_src;
    logic [SRC_W-1:0]       r_prev_code;
    logic                   r_prev_valid;
    logic [3:0][DATA_W-1:0] r_stage,     w_stage;
    res_mat_t               r_res_pe,    w_res_pe;
    res_mat_t               r_res_3x3,   w_res_3x3;
    res_mat_t               r_res_2x2,   w_res_2x2;
    logic [NSRC-1:0]        r_have,      w_have;
    logic                   r_done,      w_done;
    logic                   r_match,     w_match;
    logic                   r_proto_err, w_proto_err;

    logic [SRC_W-1:0]       w_code;
    logic                   w_legal;
    logic                   w_bad;
    logic                   w_switch;
    logic                   w_start;
    logic                   w_run;
    res_mat_t               w_mat;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_sample;
    logic                   w_last;

    // Window start/continue decode; kept free of sampler outputs to avoid a comb loop
    always_comb begin
        w_code   = bus.display_current_state;
        w_legal  = is_legal_src(w_code);
        w_bad    = (w_code != SRC_IDLE) && !w_legal;
        w_switch = (r_state == ST_CAPTURE) && (w_code != r_cur_src);
        w_start  = !bus.clear && w_legal &&
                   (((r_state == ST_IDLE) && r_prev_valid && (w_code != r_prev_code)) || w_switch);
        w_run    = !bus.clear && (r_state == ST_CAPTURE) && !w_switch;
    end

    elem_sampler #(
        .HOLD (HOLD)
    ) u_sampler (
        .clk               (clk),
        .rst_n             (reset),
        .i_clear           (bus.clear),
        .i_start           (w_start),
        .i_run             (w_run),
        .o_idx_c           (w_idx),
        .o_sample_strobe_c (w_sample),
        .o_last_elem_c     (w_last)
    );

    always_comb begin
        w_state     = r_state;
        w_cur_src   = r_cur_src;
        w_stage     = r_stage;
        w_res_pe    = r_res_pe;
        w_res_3x3   = r_res_3x3;
        w_res_2x2   = r_res_2x2;
        w_have      = r_have;
        w_done      = r_done;
        w_match     = r_match;
        w_proto_err = r_proto_err;
        w_mat       = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_bad) w_proto_err = 1'b1;
                if (w_start) begin
                    w_cur_src = w_code;
                    w_state   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // A switch to another legal source aborts this window and opens that one
                if (w_switch) begin
                    w_proto_err = 1'b1;
                    w_stage     = '0;
                    w_state     = w_start ? ST_CAPTURE : ST_IDLE;
                    if (w_start) w_cur_src = w_code;
                end
            end
            ST_CHECK: begin
                if (w_bad) w_proto_err = 1'b1;
                w_done  = 1'b1;
                w_match = (r_res_pe == r_res_3x3) && (r_res_3x3 == r_res_2x2);
                w_state = ST_DONE;
            end
            ST_DONE: begin
            end
            default: w_state = ST_IDLE;
        endcase

        if (w_sample) w_stage[w_idx] = bus.display_result;

        if (w_last) begin
            w_mat = pack_res(w_stage[0], w_stage[1], w_stage[2], w_stage[3]);
            case (w_cur_src)
                SRC_PE:  begin w_res_pe  = w_mat; w_have[0] = 1'b1; end
                SRC_SA3: begin w_res_3x3 = w_mat; w_have[1] = 1'b1; end
                SRC_SA2: begin w_res_2x2 = w_mat; w_have[2] = 1'b1; end
                default: ;
            endcase
            w_state = (&w_have) ? ST_CHECK : ST_IDLE;
        end

        if (bus.clear) begin
            w_state     = ST_IDLE;
            w_cur_src   = SRC_IDLE;
            w_stage     = '0;
            w_res_pe    = '0;
            w_res_3x3   = '0;
            w_res_2x2   = '0;
            w_have      = '0;
            w_done      = 1'b0;
            w_match     = 1'b0;
            w_proto_err = 1'b0;
        end
    end

    // Previous code keeps tracking through clear so a window open during clear is never picked up mid-way
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cur_src    <= SRC_IDLE;
            r_prev_code  <= SRC_IDLE;
            r_prev_valid <= 1'b0;
            r_stage      <= '0;
            r_res_pe     <= '0;
            r_res_3x3    <= '0;
            r_res_2x2    <= '0;
            r_have       <= '0;
            r_done       <= 1'b0;
            r_match      <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cur_src    <= w_cur_src;
            r_prev_code  <= w_code;
            r_prev_valid <= 1'b1;
            r_stage      <= w_stage;
            r_res_pe     <= w_res_pe;
            r_res_3x3    <= w_res_3x3;
            r_res_2x2    <= w_res_2x2;
            r_have       <= w_have;
            r_done       <= w_done;
            r_match      <= w_match;
            r_proto_err  <= w_proto_err;
        end
    end

    assign bus.res_pe    = r_res_pe;
    assign bus.res_3x3   = r_res_3x3;
    assign bus.res_2x2   = r_res_2x2;
    assign bus.have      = r_have;
    assign bus.done      = r_done;
    assign bus.match     = r_match;
    assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture: HOLD=1 and HOLD=4 instances driven by one linear stimulus sequence.
module tb_display_capture;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    display_capture_if if1 ();
    display_capture_if if4 ();

    display_capture #(.HOLD(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    display_capture #(.HOLD(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step1c(input logic [2:0] code, input logic [7:0] data, input logic clr);
        if1.display_current_state = code;
        if1.display_result        = data;
        if1.clear                 = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic [2:0] code, input logic [7:0] data);
        step1c(code, data, 1'b0);
    endtask

    task automatic step4(input logic [2:0] code, input logic [7:0] data);
        if4.display_current_state = code;
        if4.display_result        = data;
        if4.clear                 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic win1(input logic [2:0] code, input logic [31:0] m);
        for (int e = 0; e < 4; e++) step1(code, m[31-8*e -: 8]);
    endtask

    task automatic win4(input logic [2:0] code, input logic [31:0] m);
        for (int e = 0; e < 4; e++)
            for (int h = 0; h < 4; h++) step4(code, m[31-8*e -: 8]);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_res_pe"},  if1.res_pe,  32'h0);
        chk({tag, "_res_3x3"}, if1.res_3x3, 32'h0);
        chk({tag, "_res_2x2"}, if1.res_2x2, 32'h0);
        chk({tag, "_have"},    32'(if1.have), 32'h0);
        chk({tag, "_done"},    32'(if1.done), 32'h0);
        chk({tag, "_match"},   32'(if1.match), 32'h0);
        chk({tag, "_proto"},   32'(if1.proto_err), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        if1.clear = 1'b0; if1.display_result = '0; if1.display_current_state = '0;
        if4.clear = 1'b0; if4.display_result = '0; if4.display_current_state = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero1("reset");
        chk("reset4_have", 32'(if4.have), 32'h0);
        reset = 1'b1;
        step1(3'd0, 8'h00);
        step1(3'd0, 8'h00);

        // HOLD=1, three agreeing matrices back to back
        win1(3'd1, 32'h01020304);
        chk("t1_res_pe", if1.res_pe, 32'h01020304);
        chk("t1_have_pe", 32'(if1.have), 32'h1);
        win1(3'd2, 32'h01020304);
        win1(3'd3, 32'h01020304);
        chk("t1_res_3x3", if1.res_3x3, 32'h01020304);
        chk("t1_res_2x2", if1.res_2x2, 32'h01020304);
        chk("t1_have_all", 32'(if1.have), 32'h7);
        chk("t1_done_early", 32'(if1.done), 32'h0);
        step1(3'd0, 8'h00);
        chk("t1_done", 32'(if1.done), 32'h1);
        chk("t1_match", 32'(if1.match), 32'h1);
        step1(3'd5, 8'h00);
        chk("t1_done_ignores_bad", 32'(if1.proto_err), 32'h0);
        step1(3'd0, 8'h00);

        // HOLD=4, 2x2 disagrees in c22
        win4(3'd1, 32'h01020304);
        win4(3'd2, 32'h01020304);
        win4(3'd3, 32'h01020305);
        chk("t2_res_pe", if4.res_pe, 32'h01020304);
        chk("t2_res_2x2", if4.res_2x2, 32'h01020305);
        chk("t2_done_early", 32'(if4.done), 32'h0);
        step4(3'd0, 8'h00);
        chk("t2_done", 32'(if4.done), 32'h1);
        chk("t2_match", 32'(if4.match), 32'h0);

        // HOLD=1, switch from PE to SA_3x3 after two elements
        step1c(3'd0, 8'h00, 1'b1);
        chk_zero1("t3_clear");
        step1(3'd1, 8'h01);
        step1(3'd1, 8'h02);
        chk("t3_no_err_yet", 32'(if1.proto_err), 32'h0);
        step1(3'd2, 8'h11);
        chk("t3_proto", 32'(if1.proto_err), 32'h1);
        step1(3'd2, 8'h12);
        step1(3'd2, 8'h13);
        step1(3'd2, 8'h14);
        chk("t3_have", 32'(if1.have), 32'h2);
        chk("t3_res_3x3", if1.res_3x3, 32'h11121314);
        chk("t3_res_pe", if1.res_pe, 32'h0);
        step1(3'd0, 8'h00);

        // HOLD=1, illegal code in IDLE
        step1c(3'd0, 8'h00, 1'b1);
        step1(3'd5, 8'hAA);
        chk("t4_proto", 32'(if1.proto_err), 32'h1);
        step1(3'd0, 8'h00);
        chk("t4_have", 32'(if1.have), 32'h0);
        chk("t4_res_pe", if1.res_pe, 32'h0);

        // HOLD=1, reset in the middle of SA_3x3
        step1c(3'd0, 8'h00, 1'b1);
        win1(3'd1, 32'h0A0B0C0D);
        chk("t5_res_pe_pre", if1.res_pe, 32'h0A0B0C0D);
        step1(3'd2, 8'h01);
        step1(3'd2, 8'h02);
        if1.display_result = 8'h03;
        reset = 1'b0;
        #1;
        chk_zero1("t5_async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step1(3'd2, 8'h04);
        chk("t5_no_partial", 32'(if1.have), 32'h0);
        step1(3'd0, 8'h00);
        win1(3'd1, 32'h01020304);
        win1(3'd2, 32'h01020304);
        win1(3'd3, 32'h01020304);
        step1(3'd0, 8'h00);
        chk("t5_done", 32'(if1.done), 32'h1);
        chk("t5_match", 32'(if1.match), 32'h1);

        // HOLD=1, clear coinciding with a fresh PE window
        step1c(3'd1, 8'h21, 1'b1);
        chk_zero1("t6_clear");
        step1(3'd1, 8'h22);
        step1(3'd1, 8'h23);
        step1(3'd1, 8'h24);
        step1(3'd0, 8'h00);
        chk("t6_have", 32'(if1.have), 32'h0);
        chk("t6_res_pe", if1.res_pe, 32'h0);
        chk("t6_done", 32'(if1.done), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
